// File: rtl/model_buffer_pkg.sv
// rtl/model_buffer_pkg.sv - shared types for the model triangle buffer
package model_buffer_pkg;

  typedef logic [15:0] short_t;

  typedef struct packed {
    short_t x;
    short_t y;
    short_t z;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    short_t model_index;
    short_t triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

endpackage

// File: rtl/model_buffer.sv
// rtl/model_buffer.sv - per-model triangle store with append-only loading and registered reads
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   clear               pulse: invalidate every model and free all triangle storage
//   write_*             load stream; write_model_index is taken from the first triangle
//                       of each model, write_last closes the model and commits it
//   read_in_*           request {model_index, triangle_index}
//   read_out_*          registered response; metadata.last marks the model's final
//                       triangle or an error terminator (zero triangle)
//   overflow            sticky; a load ran out of triangle RAM
module model_buffer
  import model_buffer_pkg::*;
#(
  parameter int MAX_MODEL_COUNT    = 10,
  parameter int MAX_TRIANGLE_COUNT = 100
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clear,
  input  logic           write_valid,
  output logic           write_ready,
  input  short_t         write_model_index,
  input  triangle_t      write_data,
  input  logic           write_last,
  input  logic           read_in_valid,
  output logic           read_in_ready,
  input  modelbuf_read_t read_in_data,
  output logic           read_out_valid,
  input  logic           read_out_ready,
  output triangle_t      read_out_data,
  output triangle_meta_t read_out_metadata,
  output logic           overflow
);

  // Address width holds MAX_TRIANGLE_COUNT itself so "RAM full" is representable.
  localparam int AW = $clog2(MAX_TRIANGLE_COUNT + 1);
  localparam int MW = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1;

  typedef logic [AW-1:0] addr_t;

  localparam addr_t  RAM_END   = addr_t'(MAX_TRIANGLE_COUNT);
  localparam short_t MODEL_END = short_t'(MAX_MODEL_COUNT);

  typedef enum logic {IDLE, LOADING} load_state_t;

  load_state_t state, state_nxt;

  short_t  cur_model;
  addr_t   cur_start, cur_count, alloc_ptr;
  logic    overflow_q;

  logic    tbl_valid [MAX_MODEL_COUNT];
  addr_t   tbl_start [MAX_MODEL_COUNT];
  addr_t   tbl_count [MAX_MODEL_COUNT];

  triangle_t ram [MAX_TRIANGLE_COUNT];
  triangle_t ram_q;

  // Load-side working values: in IDLE the first triangle supplies model/start.
  short_t          eff_model;
  addr_t           eff_start, eff_count, wr_addr;
  logic            eff_drop, ram_full, wr_fire, ram_we, commit;
  logic [MW-1:0]   wr_idx;

  assign write_ready = 1'b1;

  always_comb begin
    eff_model = (state == IDLE) ? write_model_index : cur_model;
    eff_start = (state == IDLE) ? alloc_ptr : cur_start;
    eff_count = (state == IDLE) ? addr_t'(0) : cur_count;
    eff_drop  = (eff_model >= MODEL_END);
    wr_addr   = eff_start + eff_count;
    ram_full  = (wr_addr == RAM_END);
    wr_fire   = write_valid && !clear;
    ram_we    = wr_fire && !eff_drop && !ram_full;
    // A full RAM stops the count, so a discarded last triangle means an overflowed load.
    commit    = ram_we && write_last;
    wr_idx    = eff_model[MW-1:0];

    state_nxt = state;
    if (clear)        state_nxt = IDLE;
    else if (wr_fire) state_nxt = write_last ? IDLE : LOADING;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cur_model  <= '0;
      cur_start  <= '0;
      cur_count  <= '0;
      alloc_ptr  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < MAX_MODEL_COUNT; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_start[i] <= '0;
        tbl_count[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (clear) begin
        alloc_ptr  <= '0;
        overflow_q <= 1'b0;
        for (int i = 0; i < MAX_MODEL_COUNT; i++) tbl_valid[i] <= 1'b0;
      end else if (wr_fire) begin
        cur_model <= eff_model;
        cur_start <= eff_start;
        cur_count <= ram_we ? eff_count + addr_t'(1) : eff_count;
        if (!eff_drop && ram_full) overflow_q <= 1'b1;
        if (commit) begin
          tbl_valid[wr_idx] <= 1'b1;
          tbl_start[wr_idx] <= eff_start;
          tbl_count[wr_idx] <= eff_count + addr_t'(1);
          alloc_ptr         <= wr_addr + addr_t'(1);
        end
      end
    end
  end

  assign overflow = overflow_q;

  // Read lookup uses the table as it stands before any same-cycle commit.
  short_t        rd_m, rd_t;
  logic [MW-1:0] rd_idx;
  logic          lk_valid, rd_hit, rd_last, rd_fire;
  addr_t         lk_start, lk_count, rd_addr;
  logic          out_valid, out_hit, out_last;

  always_comb begin
    rd_m     = read_in_data.model_index;
    rd_t     = read_in_data.triangle_index;
    rd_idx   = '0;
    lk_valid = 1'b0;
    lk_start = '0;
    lk_count = '0;
    if (rd_m < MODEL_END) begin
      rd_idx   = rd_m[MW-1:0];
      lk_valid = tbl_valid[rd_idx];
      lk_start = tbl_start[rd_idx];
      lk_count = tbl_count[rd_idx];
    end
    rd_hit  = lk_valid && (rd_t < short_t'(lk_count));
    // Misses terminate the consumer's loop, so they always report last.
    rd_last = !rd_hit || (rd_t == short_t'(lk_count) - short_t'(1));
    rd_addr = lk_start + rd_t[AW-1:0];
  end

  assign read_in_ready = !out_valid || read_out_ready;
  assign rd_fire       = read_in_valid && read_in_ready;

  // RAM kept free of reset so it maps to block RAM; read-before-write ordering.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[wr_addr] <= write_data;
    if (rd_fire) ram_q <= ram[rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_fire) begin
      out_valid <= 1'b1;
      out_hit   <= rd_hit;
      out_last  <= rd_last;
    end else if (read_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Gating with out_hit zeroes error responses and the unreset RAM register.
  assign read_out_valid         = out_valid;
  assign read_out_data          = out_hit ? ram_q : '0;
  assign read_out_metadata.last = out_last;

endmodule

// File: tb/tb_model_buffer.sv
// tb/tb_model_buffer.sv - directed self-checking bench for model_buffer
module tb_model_buffer;
  import model_buffer_pkg::*;

  localparam int MODELS = 10;
  localparam int DEPTH  = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           clear = 1'b0;
  logic           write_valid = 1'b0;
  logic           write_ready;
  short_t         write_model_index = '0;
  triangle_t      write_data = '0;
  logic           write_last = 1'b0;
  logic           read_in_valid = 1'b0;
  logic           read_in_ready;
  modelbuf_read_t read_in_data = '0;
  logic           read_out_valid;
  logic           read_out_ready = 1'b1;
  triangle_t      read_out_data;
  triangle_meta_t read_out_metadata;
  logic           overflow;

  model_buffer #(.MAX_MODEL_COUNT(MODELS), .MAX_TRIANGLE_COUNT(DEPTH)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .clear             (clear),
    .write_valid       (write_valid),
    .write_ready       (write_ready),
    .write_model_index (write_model_index),
    .write_data        (write_data),
    .write_last        (write_last),
    .read_in_valid     (read_in_valid),
    .read_in_ready     (read_in_ready),
    .read_in_data      (read_in_data),
    .read_out_valid    (read_out_valid),
    .read_out_ready    (read_out_ready),
    .read_out_data     (read_out_data),
    .read_out_metadata (read_out_metadata),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic triangle_t mk_tri(input int n);
    triangle_t t;
    for (int i = 0; i < 9; i++) t[i*16 +: 16] = 16'(n * 16 + i);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tri(input int m, input triangle_t d, input logic last);
    write_valid       = 1'b1;
    write_model_index = short_t'(m);
    write_data        = d;
    write_last        = last;
    step();
    write_valid = 1'b0;
    write_last  = 1'b0;
  endtask

  task automatic load(input int m, input int first, input int n);
    for (int i = 0; i < n; i++) write_tri(m, mk_tri(first + i), (i == n - 1));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic set_req(input int m, input int t);
    read_in_valid = 1'b1;
    read_in_data  = '{model_index: short_t'(m), triangle_index: short_t'(t)};
  endtask

  task automatic check_resp(input string tag, input triangle_t exp_d, input logic exp_last);
    check_eq({tag, ".valid"}, read_out_valid, 1'b1);
    check_eq({tag, ".data"}, read_out_data, exp_d);
    check_eq({tag, ".last"}, read_out_metadata.last, exp_last);
  endtask

  task automatic read_chk(input string tag, input int m, input int t,
                          input triangle_t exp_d, input logic exp_last);
    set_req(m, t);
    step();
    read_in_valid = 1'b0;
    check_resp(tag, exp_d, exp_last);
  endtask

  initial begin
    step();
    step();
    check_eq("rst.write_ready", write_ready, 1'b1);
    check_eq("rst.read_in_ready", read_in_ready, 1'b1);
    check_eq("rst.out_valid", read_out_valid, 1'b0);
    check_eq("rst.out_data", read_out_data, '0);
    check_eq("rst.out_last", read_out_metadata.last, 1'b0);
    check_eq("rst.overflow", overflow, 1'b0);
    rstn = 1'b1;
    step();

    // Model 2 = A,B,C; back-to-back reads, first response one cycle after request.
    load(2, 1, 3);
    for (int i = 0; i < 3; i++) begin
      set_req(2, i);
      step();
      check_resp($sformatf("b2b%0d", i), mk_tri(1 + i), (i == 2));
    end
    read_in_valid = 1'b0;
    step();

    // Backpressure: response A held, queued request (2,1) waits.
    read_out_ready = 1'b0;
    set_req(2, 0);
    step();
    set_req(2, 1);
    for (int k = 0; k < 4; k++) begin
      check_resp($sformatf("hold%0d", k), mk_tri(1), 1'b0);
      check_eq($sformatf("hold%0d.in_ready", k), read_in_ready, 1'b0);
      step();
    end
    read_out_ready = 1'b1;
    #1;
    check_eq("release.in_ready", read_in_ready, 1'b1);
    step();
    read_in_valid = 1'b0;
    check_resp("release", mk_tri(2), 1'b0);
    step();
    check_eq("drain.valid", read_out_valid, 1'b0);

    // Two models, out-of-range triangle, unloaded and out-of-range models.
    do_clear();
    load(0, 4, 2);
    load(1, 6, 1);
    read_chk("m1t0", 1, 0, mk_tri(6), 1'b1);
    read_chk("m0t0", 0, 0, mk_tri(4), 1'b0);
    read_chk("m0t1", 0, 1, mk_tri(5), 1'b1);
    read_chk("m0t2", 0, 2, '0, 1'b1);
    read_chk("m5", 5, 0, '0, 1'b1);
    read_chk("m12", 12, 0, '0, 1'b1);
    read_chk("cleared.m2", 2, 0, '0, 1'b1);

    // Overflow: model 1 needs 3 slots, only 1 left.
    do_clear();
    load(0, 1, 3);
    load(1, 4, 3);
    check_eq("ovf.flag", overflow, 1'b1);
    read_chk("ovf.m1", 1, 0, '0, 1'b1);
    read_chk("ovf.m0t2", 0, 2, mk_tri(3), 1'b1);
    read_chk("ovf.m0t0", 0, 0, mk_tri(1), 1'b0);
    do_clear();
    check_eq("clr.flag", overflow, 1'b0);
    read_chk("clr.m0", 0, 0, '0, 1'b1);

    // Out-of-range model consumes no storage: a full-depth load still fits.
    load(12, 7, 3);
    check_eq("drop.flag", overflow, 1'b0);
    load(3, 7, 4);
    check_eq("fill.flag", overflow, 1'b0);
    read_chk("fill.t3", 3, 3, mk_tri(10), 1'b1);
    read_chk("fill.t0", 3, 0, mk_tri(7), 1'b0);
    read_chk("drop.m12", 12, 0, '0, 1'b1);

    // Reload model 0 while reading it: old until after the last write.
    do_clear();
    load(0, 1, 2);
    set_req(0, 0);
    write_valid = 1'b1; write_model_index = 16'd0; write_data = mk_tri(4); write_last = 1'b0;
    step();
    check_resp("reload.old0", mk_tri(1), 1'b0);
    write_data = mk_tri(5); write_last = 1'b1;
    step();
    write_valid = 1'b0; write_last = 1'b0;
    check_resp("reload.old1", mk_tri(1), 1'b0);
    step();
    read_in_valid = 1'b0;
    check_resp("reload.new", mk_tri(4), 1'b0);
    read_chk("reload.t1", 0, 1, mk_tri(5), 1'b1);

    // Reset in the middle of a load with a response pending.
    do_clear();
    load(1, 1, 2);
    write_tri(2, mk_tri(3), 1'b0);
    read_out_ready = 1'b0;
    read_chk("pre_rst", 1, 0, mk_tri(1), 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("midrst.valid", read_out_valid, 1'b0);
    check_eq("midrst.data", read_out_data, '0);
    check_eq("midrst.last", read_out_metadata.last, 1'b0);
    check_eq("midrst.in_ready", read_in_ready, 1'b1);
    check_eq("midrst.write_ready", write_ready, 1'b1);
    check_eq("midrst.overflow", overflow, 1'b0);
    step();
    rstn = 1'b1;
    read_out_ready = 1'b1;
    step();
    read_chk("postrst.m1", 1, 0, '0, 1'b1);
    read_chk("postrst.m2", 2, 0, '0, 1'b1);
    load(4, 5, 1);
    read_chk("postrst.m4", 4, 0, mk_tri(5), 1'b1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
